fetch_queue: RTL and testbench

- Parametrised, multi-wide successor to the single-instruction fetch stage.
- Owns the architectural fetch PC and fetches FETCH_WIDTH consecutive instructions per cycle from the combinational ICache.
- Writes them into a DEPTH-entry circular instruction queue.
- Delivers one {pc, instr} per cycle to decode over a valid/ready handshake; mispredict flushes the queue and redirects the PC.

---
 rtl/fetch_queue_if.sv | 50 +++++
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Bundles the fetch queue's two buses: the ICache lookup (address out,
// FETCH_WIDTH words back in the same cycle) and the decode-side
// valid/ready head-of-queue port.
//   icache_addr  fetch PC presented to the ICache
//   icache_data  FETCH_WIDTH instruction words, word i at icache_addr + 4*i
//   ready_out    decode accepts the head entry
//   valid_out    head entry valid
//   instr_out    head instruction
//   pc_out       head PC
//   pc_4         pc_out + 4
//   count_out    queue occupancy
// The master modport is the fetch queue; the slave modport is the ICache/decode side.
interface fetch_queue_if #(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned DEPTH       = 8
) ();

   logic [31:0]               icache_addr;
   logic [32*FETCH_WIDTH-1:0] icache_data;
   logic                      ready_out;
   logic                      valid_out;
   logic [31:0]               instr_out;
   logic [31:0]               pc_out;
   logic [31:0]               pc_4;
   logic [$clog2(DEPTH):0]    count_out;

   modport master (
      output icache_addr,
      input  icache_data,
      input  ready_out,
      output valid_out,
      output instr_out,
      output pc_out,
      output pc_4,
      output count_out
   );

   modport slave (
      input  icache_addr,
      output icache_data,
      output ready_out,
      input  valid_out,
      input  instr_out,
      input  pc_out,
      input  pc_4,
      input  count_out
   );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Owns the architectural fetch PC, fetches FETCH_WIDTH consecutive
// instructions per cycle from a combinational ICache and writes them into a
// DEPTH-entry circular queue. The head entry is handed to decode one per
// cycle over valid/ready. A mispredict flushes the queue and redirects fetch.
// Ports:
//   clk          clock, all state on the rising edge
//   reset        synchronous active-low reset (priority over everything)
//   mispredict   flush queue, load fetch PC from redirect_pc
//   redirect_pc  redirect target, word aligned
//   fetch_en     0 suppresses new fetches; the queue still drains
//   bus          ICache and decode signals (fetch_queue_if.master)
module fetch_queue #(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned DEPTH       = 8,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   input logic           mispredict,
   input logic [31:0]    redirect_pc,
   input logic           fetch_en,
   fetch_queue_if.master bus
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
   localparam logic [CntW-1:0] WidthC  = CntW'(FETCH_WIDTH);
   localparam logic [PtrW-1:0] WidthP  = PtrW'(FETCH_WIDTH);
   localparam logic [31:0]     StrideC = 32'(4 * FETCH_WIDTH);

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   // Each entry is {pc, instr}.
   logic [63:0] mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic            valid;
   logic [CntW-1:0] free;
   logic [63:0]     head;

   // ---------------------------------------------------------------------
   // Handshake decisions
   // ---------------------------------------------------------------------
   always_comb begin
      free  = DepthC - count_q;
      // Free space is judged on registered count only; a same-cycle pop is
      // deliberately not credited so the push decision has no path from
      // ready_out.
      push  = fetch_en && !mispredict && (free >= WidthC);
      valid = (count_q != '0);
      pop   = valid && bus.ready_out && !mispredict;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (mispredict) begin
         // Any push/pop of this cycle is dropped along with the queue.
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + WidthP;
            fetch_pc_d = fetch_pc_q + StrideC;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + (push ? WidthC : '0) - (pop ? CntW'(1) : '0);
      end
   end

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // ---------------------------------------------------------------------
   // Queue storage (no reset; contents are only read while count != 0)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset && push) begin
         for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            // Pointer arithmetic wraps naturally because DEPTH is a power of 2.
            mem_q[wr_ptr_q + PtrW'(i)] <= {fetch_pc_q + 32'(4 * i),
                                            bus.icache_data[32*i +: 32]};
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      head            = mem_q[rd_ptr_q];
      bus.icache_addr = fetch_pc_q;
      bus.valid_out   = valid;
      bus.count_out   = count_q;
      // Force zeros when empty so stale storage never leaks out.
      bus.instr_out   = valid ? head[31:0]  : 32'h0;
      bus.pc_out      = valid ? head[63:32] : 32'h0;
      bus.pc_4        = bus.pc_out + 32'd4;
   end

   // Occupancy can never exceed the queue depth.
   count_bound_a : assert property (@(posedge clk) disable iff (!reset) count_q <= DepthC);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed bench for fetch_queue (FETCH_WIDTH=2, DEPTH=8). The stimulus
// process queues the PC stream it expects decode to see after each
// reset/redirect; a monitor pops one expected entry per accepted handshake
// and compares pc, instr and pc_4. Point checks cover reset values, full
// stall, mispredict timing, drain and address wrap.
module tb_fetch_queue;

   localparam int unsigned FW = 2;
   localparam int unsigned D  = 8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        fetch_en;
   logic        ready;

   logic [32*FW-1:0] ic_data;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;

   fetch_queue_if #(.FETCH_WIDTH(FW), .DEPTH(D)) bus ();

   fetch_queue #(
      .FETCH_WIDTH (FW),
      .DEPTH       (D),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mispredict  (mispredict),
      .redirect_pc (redirect_pc),
      .fetch_en    (fetch_en),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ICache contents: a fixed scramble of the address.
   function automatic logic [31:0] imem(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   always_comb begin
      ic_data = '0;
      for (int i = 0; i < int'(FW); i++) begin
         ic_data[32*i +: 32] = imem(bus.icache_addr + 32'(4 * i));
      end
   end

   assign bus.icache_data = ic_data;
   assign bus.ready_out   = ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_from(input logic [31:0] start, input int n);
      sb_q.delete();
      for (int i = 0; i < n; i++) begin
         sb_q.push_back('{pc: start + 32'(4 * i), instr: imem(start + 32'(4 * i))});
      end
   endtask

   // Monitor: compares every accepted head entry against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1) begin
         check("count_le_depth", 32'(bus.count_out > 4'd8), 32'd0);
         if (bus.valid_out && ready && !mispredict) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("sb_pc", bus.pc_out, e.pc);
               check("sb_instr", bus.instr_out, e.instr);
               check("sb_pc_4", bus.pc_4, e.pc + 32'd4);
               pops++;
            end
         end
      end
   end

   initial begin
      int p0;
      reset       = 1'b0;
      mispredict  = 1'b0;
      redirect_pc = 32'h0;
      fetch_en    = 1'b0;
      ready       = 1'b0;

      // Reset values
      repeat (2) step();
      @(negedge clk);
      check("rst_valid", 32'(bus.valid_out), 32'd0);
      check("rst_instr", bus.instr_out, 32'h0);
      check("rst_pc", bus.pc_out, 32'h0);
      check("rst_pc_4", bus.pc_4, 32'h4);
      check("rst_count", 32'(bus.count_out), 32'd0);
      check("rst_icache", bus.icache_addr, 32'h0);

      // Streaming with ready high
      step();
      expect_from(32'h0, 256);
      reset    = 1'b1;
      fetch_en = 1'b1;
      ready    = 1'b1;
      @(negedge clk);
      check("str_icache0", bus.icache_addr, 32'h0);
      check("str_empty_valid", 32'(bus.valid_out), 32'd0);
      step();
      @(negedge clk);
      check("str_icache1", bus.icache_addr, 32'h8);
      check("str_count1", 32'(bus.count_out), 32'd2);
      check("str_head0", bus.pc_out, 32'h0);
      p0 = pops;
      repeat (20) step();
      check("str_pops", 32'(pops - p0 >= 15), 32'd1);

      // Fill with ready low
      reset = 1'b0;
      ready = 1'b0;
      step();
      expect_from(32'h0, 256);
      reset = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check("full_count", 32'(bus.count_out), 32'd8);
      check("full_icache", bus.icache_addr, 32'h20);
      check("full_valid", 32'(bus.valid_out), 32'd1);
      check("full_pc", bus.pc_out, 32'h0);
      repeat (3) step();
      @(negedge clk);
      check("hold_icache", bus.icache_addr, 32'h20);
      check("hold_pc", bus.pc_out, 32'h0);
      check("hold_instr", bus.instr_out, imem(32'h0));
      check("hold_count", 32'(bus.count_out), 32'd8);
      step();
      ready = 1'b1;
      p0    = pops;
      repeat (10) step();
      check("resume_pops", 32'(pops - p0 >= 9), 32'd1);

      // Refill, then mispredict from a full queue
      ready = 1'b0;
      repeat (6) step();
      @(negedge clk);
      check("refull", 32'(bus.count_out >= 4'd7), 32'd1);
      step();
      mispredict  = 1'b1;
      redirect_pc = 32'h100;
      ready       = 1'b1;
      expect_from(32'h100, 256);
      step();
      mispredict = 1'b0;
      @(negedge clk);
      check("mp_valid", 32'(bus.valid_out), 32'd0);
      check("mp_count", 32'(bus.count_out), 32'd0);
      check("mp_icache", bus.icache_addr, 32'h100);
      step();
      @(negedge clk);
      check("mp_head", bus.pc_out, 32'h100);
      check("mp_head_valid", 32'(bus.valid_out), 32'd1);

      // Back-to-back mispredicts: last target wins
      step();
      mispredict  = 1'b1;
      redirect_pc = 32'h300;
      step();
      redirect_pc = 32'h400;
      expect_from(32'h400, 256);
      step();
      mispredict = 1'b0;
      @(negedge clk);
      check("mp2_icache", bus.icache_addr, 32'h400);
      step();
      @(negedge clk);
      check("mp2_head", bus.pc_out, 32'h400);

      // Random ready_out
      p0 = pops;
      for (int i = 0; i < 200; i++) begin
         ready = 1'($urandom_range(0, 1));
         step();
      end
      check("rand_pops", 32'(pops - p0 >= 50), 32'd1);

      // Drain with fetch disabled
      fetch_en = 1'b0;
      ready    = 1'b1;
      repeat (12) step();
      @(negedge clk);
      check("drain_count", 32'(bus.count_out), 32'd0);
      check("drain_valid", 32'(bus.valid_out), 32'd0);
      check("drain_pc", bus.pc_out, 32'h0);
      check("drain_instr", bus.instr_out, 32'h0);
      check("drain_icache", bus.icache_addr, sb_q[0].pc);

      // Reset beats a simultaneous mispredict
      step();
      reset       = 1'b0;
      mispredict  = 1'b1;
      redirect_pc = 32'h200;
      expect_from(32'h0, 256);
      step();
      reset      = 1'b1;
      mispredict = 1'b0;
      fetch_en   = 1'b1;
      @(negedge clk);
      check("rm_icache", bus.icache_addr, 32'h0);
      check("rm_count", 32'(bus.count_out), 32'd0);
      check("rm_valid", 32'(bus.valid_out), 32'd0);
      step();
      @(negedge clk);
      check("rm_head", bus.pc_out, 32'h0);

      // Address wrap at the top of memory
      step();
      mispredict  = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      expect_from(32'hFFFF_FFF8, 256);
      step();
      mispredict = 1'b0;
      step();
      @(negedge clk);
      check("wrap_head0", bus.pc_out, 32'hFFFF_FFF8);
      step();
      @(negedge clk);
      check("wrap_head1", bus.pc_out, 32'hFFFF_FFFC);
      check("wrap_pc_4", bus.pc_4, 32'h0);
      step();
      @(negedge clk);
      check("wrap_head2", bus.pc_out, 32'h0);
      check("wrap_instr2", bus.instr_out, imem(32'h0));

      repeat (5) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
